// File: rtl/matrix_pkg.sv
// Shared constants and types for the 2x2 matrix multiplier datapath and its result buffer.
package matrix_pkg;

  localparam int MATRIX_LATENCY = 5;
  localparam int RES_W          = 17;
  localparam int RES_DEPTH      = 8;

  typedef struct packed {
    logic [RES_W-1:0] y;
    logic [RES_W-1:0] z;
  } res_pair_t;

  function automatic logic [5:0] ones32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/matrix_result_buffer_fifo.sv
// Generic show-ahead FIFO: the head word is always visible on data_o while not empty.
module sync_fifo_sa #(
  parameter int W     = 34,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;
  logic          push_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign pop_eff  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign push_eff = push_i & (~full_o | pop_eff);
  assign data_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_eff) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/matrix_result_buffer.sv
// Tracks sample validity through the fixed-latency multiplier and buffers each Y/Z result,
// issuing credit-based in_ready so the FIFO can always absorb what is in flight.
module matrix_result_buffer
  import matrix_pkg::*;
#(
  parameter int LATENCY = MATRIX_LATENCY,
  parameter int DW      = RES_W,
  parameter int DEPTH   = RES_DEPTH,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] z_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] z_out,
  output logic [CW-1:0] count,
  output logic          ovf,
  input  logic          ovf_clr
);

  // Handshakes: a result transfers on a cycle with out_valid && out_ready, and out_valid
  // never depends on out_ready. On the input side in_ready is a credit: the source may
  // raise in_valid only while it is high, and a raised in_valid always enters the delay line.
  localparam int SW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY:1] vd_q, vd_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             ovf_set;
  logic [5:0]       inflight;
  logic [SW-1:0]    credit_used;
  logic [2*DW-1:0]  head;

  always_comb begin
    vd_d    = vd_q;
    vd_d[1] = in_valid;
    for (int i = 2; i <= LATENCY; i++) begin
      vd_d[i] = vd_q[i-1];
    end
  end

  assign push    = vd_q[LATENCY];
  assign pop     = out_valid & out_ready;
  assign ovf_set = push & full & ~pop;
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      vd_q  <= vd_d;
      ovf_q <= ovf_d;
    end
  end

  sync_fifo_sa #(
    .W     (2 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({y_in, z_in}),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid = ~empty;
  assign y_out     = head[2*DW-1:DW];
  assign z_out     = head[DW-1:0];
  assign ovf       = ovf_q;

  // Same-cycle pops are deliberately not credited, so in_ready uses registered state only.
  assign inflight    = ones32(32'(vd_q));
  assign credit_used = SW'(count) + SW'(inflight);
  assign in_ready    = (credit_used < SW'(DEPTH));

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Bench for matrix_result_buffer: a stand-in multiplier delays per-sample data, and a
// queue model of the buffer is compared with the DUT on every falling edge.
module tb_matrix_result_buffer;
  import matrix_pkg::*;

  localparam int LAT   = MATRIX_LATENCY;
  localparam int DW    = RES_W;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W2    = 2 * DW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr   = 1'b0;
  logic [DW-1:0] y_in      = '0;
  logic [DW-1:0] z_in      = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] y_out;
  logic [DW-1:0] z_out;
  logic [CW-1:0] count;
  logic          ovf;

  matrix_result_buffer #(
    .LATENCY (LAT),
    .DW      (DW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .z_out     (z_out),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- report helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier stand-in + driver tasks ----------------
  // ab_cur is the result the multiplier will produce for the sample presented this cycle.
  res_pair_t ab_cur;
  res_pair_t mp [LAT];

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = LAT - 1; k > 0; k--) mp[k] = mp[k-1];
    mp[0] = ab_cur;
    y_in  = mp[LAT-1].y;
    z_in  = mp[LAT-1].z;
    ab_cur.y = DW'($urandom());
    ab_cur.z = DW'($urandom());
  endtask

  task automatic present(input logic [DW-1:0] y, input logic [DW-1:0] z);
    in_valid = 1'b1;
    ab_cur.y = y;
    ab_cur.z = z;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [W2-1:0] exp_q[$];
  int            issue_q[$];
  int            mcyc    = 0;
  logic          exp_ovf = 1'b0;
  bit            m_push, m_pop, m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      issue_q.delete();
      exp_ovf = 1'b0;
      mcyc    = 0;
    end else begin
      m_push = (issue_q.size() > 0) && (issue_q[0] == mcyc - LAT);
      if (m_push) void'(issue_q.pop_front());
      m_pop  = (exp_q.size() != 0) && out_ready;
      m_drop = m_push && (exp_q.size() == DEPTH) && !m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push && !m_drop) exp_q.push_back({y_in, z_in});
      if (m_drop) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      if (in_valid) issue_q.push_back(mcyc);
      mcyc++;
    end
  end

  bit            cmp_en = 1'b0;
  logic [W2-1:0] head;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("count", 64'(count), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'((exp_q.size() + issue_q.size()) < DEPTH));
      check("ovf", 64'(ovf), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("y_out", 64'(y_out), 64'(head[W2-1:DW]));
        check("z_out", 64'(z_out), 64'(head[DW-1:0]));
      end
    end
  end

  bit collect = 1'b0;
  int got[$];

  always @(negedge clk) begin
    if (collect && out_valid && out_ready) got.push_back(int'(y_out));
  end

  // ---------------- stimulus ----------------
  int acc;
  int sent;

  initial begin
    for (int k = 0; k < LAT; k++) mp[k] = '0;
    ab_cur = '0;

    // reset state
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y_out", 64'(y_out), 64'd0);
    check("rst_z_out", 64'(z_out), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (3) tick();

    // single sample: out_valid exactly LAT+1 cycles after in_valid
    present(17'h00123, 17'h1FEDC);
    repeat (4) tick();
    check("single_not_early", 64'(out_valid), 64'd0);
    tick();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_y", 64'(y_out), 64'h00123);
    check("single_z", 64'(z_out), 64'h1FEDC);
    check("single_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_count", 64'(count), 64'd0);

    // fill with stalled consumer, source obeying in_ready
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = in_ready;
      if (in_ready) begin
        acc++;
        ab_cur.y = DW'(acc);
        ab_cur.z = DW'(17'h10000 + acc);
      end
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepted", 64'(acc), 64'd8);
    check("fill_count", 64'(count), 64'd8);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_ovf", 64'(ovf), 64'd0);

    // full FIFO with push and pop in the same cycle
    present(17'h0AAAA, 17'h15555);
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("simul_count", 64'(count), 64'd8);
    check("simul_ovf", 64'(ovf), 64'd0);
    check("simul_head", 64'(y_out), 64'd2);

    // forced overflow, sticky flag, clear, clear racing a new overflow
    present(17'h0BBBB, 17'h04444);
    repeat (5) tick();
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_head", 64'(y_out), 64'd2);
    repeat (3) tick();
    check("ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    present(17'h0CCCC, 17'h03333);
    repeat (4) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);

    // wrap-around: 20 samples, consumer toggling
    collect = 1'b1;
    sent = 0;
    for (int c = 0; c < 400 && (sent < 20 || got.size() < 20); c++) begin
      out_ready = (c % 2 == 0);
      if (sent < 20 && in_ready) begin
        in_valid = 1'b1;
        sent++;
        ab_cur.y = DW'(sent);
        ab_cur.z = DW'(17'h10000 + sent);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    collect   = 1'b0;
    check("wrap_total", 64'(got.size()), 64'd20);
    for (int k = 0; k < got.size(); k++) check("wrap_order", 64'(got[k]), 64'(k + 1));

    // async reset with 4 stored and 3 in flight
    for (int i = 0; i < 4; i++) present(DW'(17'h00100 + i), DW'(i));
    repeat (6) tick();
    check("pre_rst_count", 64'(count), 64'd4);
    for (int i = 0; i < 3; i++) present(DW'(17'h00200 + i), DW'(i));
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_no_push", 64'(count), 64'd0);
    check("post_rst_no_valid", 64'(out_valid), 64'd0);

    // randomized traffic: slow consumer phase then fast consumer phase
    for (int c = 0; c < 900; c++) begin
      if (c < 450) out_ready = ($urandom_range(0, 3) == 0);
      else         out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 31) == 0);
      if (in_ready) in_valid = ($urandom_range(0, 1) == 1);
      else          in_valid = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid  = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("final_drain", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
